// File: rtl/mistral_cfg_pkg.sv
// Shared types and widths for the Mistral serial LUT4 configuration loader.
package mistral_cfg_pkg;
    localparam int MASK_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_ADDR   = 2'd0,
        ST_DATA   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;
endpackage

// File: rtl/mistral_lut_mask_bank.sv
// NUM_LUTS x 16-bit LUT4 mask storage with a combinational LUT4 read port.
module mistral_lut_mask_bank
    import mistral_cfg_pkg::*;
#(
    parameter int NUM_LUTS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [MASK_W-1:0] WDATA,
    input  logic [ADDR_W-1:0] SEL,
    input  logic              A,
    input  logic              B,
    input  logic              C,
    input  logic              D,
    output logic              Q
);
    logic [MASK_W-1:0] mask_q [NUM_LUTS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_LUTS; i++) begin
                mask_q[i] <= '0;
            end
        end else if (WE && (32'(WADDR) < NUM_LUTS)) begin
            mask_q[WADDR] <= WDATA;
        end
    end

    // Slots beyond NUM_LUTS read as an all-zero mask.
    always_comb begin
        Q = 1'b0;
        if (32'(SEL) < NUM_LUTS) begin
            Q = mask_q[SEL][{D, C, B, A}];
        end
    end
endmodule

// File: rtl/mistral_lut_cfg_loader.sv
// Bit-serial {address, mask} frame loader feeding a bank of runtime-loadable LUT4 masks.
module mistral_lut_cfg_loader
    import mistral_cfg_pkg::*;
#(
    parameter int NUM_LUTS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CFG_VALID,
    input  logic             CFG_DATA,
    output logic             CFG_READY,
    output logic             CFG_ERR,
    output logic             CFG_DONE,
    output logic [CNT_W-1:0] FRAME_CNT,
    input  logic [ADDR_W-1:0] EVAL_SEL,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    output logic             Q
);
    localparam int BIT_W = 4;

    state_e            state_q, state_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              xfer;
    logic              addr_ok;
    logic              wr_en;

    assign CFG_READY = (state_q != ST_COMMIT);
    assign xfer      = CFG_VALID && CFG_READY;
    assign addr_ok   = (32'(addr_q) < NUM_LUTS);
    assign wr_en     = (state_q == ST_COMMIT) && addr_ok;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_ADDR: begin
                if (xfer) begin
                    addr_d = ADDR_W'({addr_q, CFG_DATA});
                    if (bit_q == BIT_W'(ADDR_W - 1)) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    mask_d = {mask_q[MASK_W-2:0], CFG_DATA};
                    if (bit_q == BIT_W'(MASK_W - 1)) begin
                        state_d = ST_COMMIT;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                // Out-of-range slots are reported instead of written and not counted.
                done_d  = addr_ok;
                err_d   = !addr_ok;
                if (addr_ok) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
                state_d = ST_ADDR;
            end
            default: state_d = ST_ADDR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_ADDR;
            bit_q       <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign CFG_DONE  = done_q;
    assign CFG_ERR   = err_q;
    assign FRAME_CNT = frame_cnt_q;

    mistral_lut_mask_bank #(
        .NUM_LUTS (NUM_LUTS),
        .ADDR_W   (ADDR_W)
    ) u_bank (
        .CLK   (CLK),
        .RST   (RST),
        .WE    (wr_en),
        .WADDR (addr_q),
        .WDATA (mask_q),
        .SEL   (EVAL_SEL),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .Q     (Q)
    );
endmodule
